// File: rtl/dmem_arbiter_if.sv
// Handshake bundle between the CPU MEM stage, the DMA engine and the data RAM.
// The slave modport is the arbiter's view; the master modport is its environment.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for a single-port 1-cycle-latency data RAM; CPU write 0 stall, read 1 stall.
// CPU wins by default; a DMA denied MAX_WAIT cycles is forced through and the CPU is stalled.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0]  cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0]  dma_hold_q, dma_hold_d;
    logic               cpu_win;
    logic               dma_win;
    logic               dma_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            cpu_hold_q <= '0;
            dma_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            cpu_hold_q <= cpu_hold_d;
            dma_hold_q <= dma_hold_d;
        end
    end

    assign dma_first = bus.dma_req && (starve_q == MAX_CNT);

    always_comb begin
        state_d        = state_q;
        cpu_win        = 1'b0;
        dma_win        = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.cpu_stall  = 1'b0;
        bus.dma_gnt    = 1'b0;
        bus.dma_rvalid = 1'b0;
        bus.cpu_rdata  = cpu_hold_q;
        bus.dma_rdata  = dma_hold_q;

        case (state_q)
            IDLE: begin
                if (dma_first) begin
                    dma_win = 1'b1;
                end else if (bus.cpu_req) begin
                    cpu_win = 1'b1;
                end else if (bus.dma_req) begin
                    dma_win = 1'b1;
                end

                if (cpu_win) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.cpu_we;
                    bus.mem_addr  = bus.cpu_addr;
                    bus.mem_wdata = bus.cpu_wdata;
                    if (!bus.cpu_we) begin
                        bus.cpu_stall = 1'b1;
                        state_d       = CPU_RD;
                    end
                end

                if (dma_win) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.dma_we;
                    bus.mem_addr  = bus.dma_addr;
                    bus.mem_wdata = bus.dma_wdata;
                    bus.dma_gnt   = 1'b1;
                    bus.cpu_stall = bus.cpu_req;
                    if (!bus.dma_we) begin
                        state_d = DMA_RD;
                    end
                end
            end
            CPU_RD: begin
                bus.cpu_rdata = bus.mem_rdata;
                state_d       = IDLE;
            end
            DMA_RD: begin
                bus.dma_rvalid = 1'b1;
                bus.dma_rdata  = bus.mem_rdata;
                bus.cpu_stall  = bus.cpu_req;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nothing may reach the RAM or the requesters while reset is held.
        if (rst) begin
            bus.mem_en     = 1'b0;
            bus.mem_we     = 1'b0;
            bus.cpu_stall  = 1'b0;
            bus.dma_gnt    = 1'b0;
            bus.dma_rvalid = 1'b0;
            bus.cpu_rdata  = '0;
            bus.dma_rdata  = '0;
        end
    end

    always_comb begin
        cpu_hold_d = (state_q == CPU_RD) ? bus.mem_rdata : cpu_hold_q;
        dma_hold_d = (state_q == DMA_RD) ? bus.mem_rdata : dma_hold_q;

        if (!bus.dma_req || dma_win) begin
            starve_d = '0;
        end else if (starve_q != MAX_CNT) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table, reset/starvation/MAX_WAIT=0 sequences,
// then random traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic load;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h40) return 32'h12345678;
        return 32'hA5000000 | i;
    endfunction

    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (bus0.mem_en && !bus0.mem_we) bus0.mem_rdata <= bus0.mem_addr ^ 32'h5A5A0000;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    endtask

    task automatic drive0(input logic cr, input logic cw, input logic [31:0] ca,
                          input logic dr, input logic dw, input logic [31:0] da);
        bus0.cpu_req = cr; bus0.cpu_we = cw; bus0.cpu_addr = ca; bus0.cpu_wdata = 32'h0;
        bus0.dma_req = dr; bus0.dma_we = dw; bus0.dma_addr = da; bus0.dma_wdata = 32'hD0;
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic en, we; logic [31:0] ma;
        logic st, gn, rv;
        logic [31:0] crd, drd;
    } vec_t;
    vec_t vt [19];

    // Reference model state: pending read owner (0 none, 1 cpu, 2 dma), DMA wait, memory image.
    logic [31:0] ref_mem [256];
    int          wait_cnt;
    int          ret_owner;
    logic [7:0]  ret_addr;
    logic [31:0] last_cpu, last_dma;

    initial begin
        logic        cr, cw, dr, dw;
        logic [31:0] ca, cd, da, dd;
        logic        e_en, e_we, e_st, e_gn, e_rv;
        logic [31:0] e_addr, e_wd, e_crd, e_drd;
        int          issue, next_owner;
        logic        hold_cpu, dma_pend;

        vt[0]  = '{H,L,32'h10,32'h0,   L,L,32'h0,32'h0,   H,L,32'h10, H,L,L, 32'h0,        32'h0};
        vt[1]  = '{H,L,32'h10,32'h0,   L,L,32'h0,32'h0,   L,L,32'h0,  L,L,L, 32'hDEADBEEF, 32'h0};
        vt[2]  = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,   L,L,32'h0,  L,L,L, 32'hDEADBEEF, 32'h0};
        vt[3]  = '{H,H,32'h30,32'h1111, H,H,32'h20,32'h55, H,H,32'h30, L,L,L, 32'hDEADBEEF, 32'h0};
        vt[4]  = '{H,H,32'h31,32'h2222, H,H,32'h20,32'h55, H,H,32'h31, L,L,L, 32'hDEADBEEF, 32'h0};
        vt[5]  = '{H,H,32'h32,32'h3333, H,H,32'h20,32'h55, H,H,32'h32, L,L,L, 32'hDEADBEEF, 32'h0};
        vt[6]  = '{H,H,32'h33,32'h4444, H,H,32'h20,32'h55, H,H,32'h33, L,L,L, 32'hDEADBEEF, 32'h0};
        vt[7]  = '{H,H,32'h34,32'h5555, H,H,32'h20,32'h55, H,H,32'h20, H,H,L, 32'hDEADBEEF, 32'h0};
        vt[8]  = '{H,H,32'h34,32'h5555, L,L,32'h0,32'h0,   H,H,32'h34, L,L,L, 32'hDEADBEEF, 32'h0};
        vt[9]  = '{L,L,32'h0,32'h0,    H,L,32'h40,32'h0,  H,L,32'h40, L,H,L, 32'hDEADBEEF, 32'h0};
        vt[10] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,   L,L,32'h0,  L,L,H, 32'hDEADBEEF, 32'h12345678};
        vt[11] = '{L,L,32'h0,32'h0,    L,L,32'h0,32'h0,   L,L,32'h0,  L,L,L, 32'hDEADBEEF, 32'h12345678};
        vt[12] = '{H,L,32'h20,32'h0,   L,L,32'h0,32'h0,   H,L,32'h20, H,L,L, 32'hDEADBEEF, 32'h12345678};
        vt[13] = '{H,L,32'h20,32'h0,   L,L,32'h0,32'h0,   L,L,32'h0,  L,L,L, 32'h55,       32'h12345678};
        vt[14] = '{H,L,32'h10,32'h0,   H,L,32'h40,32'h0,  H,L,32'h10, H,L,L, 32'h55,       32'h12345678};
        vt[15] = '{H,L,32'h10,32'h0,   H,L,32'h40,32'h0,  L,L,32'h0,  L,L,L, 32'hDEADBEEF, 32'h12345678};
        vt[16] = '{L,L,32'h0,32'h0,    H,L,32'h40,32'h0,  H,L,32'h40, L,H,L, 32'hDEADBEEF, 32'h12345678};
        vt[17] = '{H,H,32'h50,32'h6666, L,L,32'h0,32'h0,  L,L,32'h0,  H,L,H, 32'hDEADBEEF, 32'h12345678};
        vt[18] = '{H,H,32'h50,32'h6666, L,L,32'h0,32'h0,  H,H,32'h50, L,L,L, 32'hDEADBEEF, 32'h12345678};

        // Reset with live requests: everything must stay quiet.
        rst = 1'b1; load = 1'b1;
        drive(H, L, 32'h10, 32'h0, H, L, 32'h40, 32'h0);
        drive0(H, L, 32'h10, H, L, 32'h40);
        bus0.mem_rdata = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst mem_en", bus.mem_en, 0);
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst cpu_stall", bus.cpu_stall, 0);
        chk("rst dma_gnt", bus.dma_gnt, 0);
        chk("rst dma_rvalid", bus.dma_rvalid, 0);
        chk("rst cpu_rdata", bus.cpu_rdata, 0);
        chk("rst dma_rdata", bus.dma_rdata, 0);
        rst = 1'b0; load = 1'b0;
        drive(L, L, 0, 0, L, L, 0, 0);
        drive0(L, L, 0, L, L, 0);

        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
            #1;
            chk($sformatf("row%0d mem_en", i), bus.mem_en, vt[i].en);
            chk($sformatf("row%0d mem_we", i), bus.mem_we, vt[i].we);
            chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vt[i].ma);
            chk($sformatf("row%0d cpu_stall", i), bus.cpu_stall, vt[i].st);
            chk($sformatf("row%0d dma_gnt", i), bus.dma_gnt, vt[i].gn);
            chk($sformatf("row%0d dma_rvalid", i), bus.dma_rvalid, vt[i].rv);
            chk($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, vt[i].crd);
            chk($sformatf("row%0d dma_rdata", i), bus.dma_rdata, vt[i].drd);
        end

        // Reset pulse during the DMA read-return cycle drops the data.
        @(posedge clk); #1;
        drive(L, L, 0, 0, H, L, 32'h40, 0);
        #1; chk("rstrd gnt", bus.dma_gnt, 1);
        @(posedge clk); #1;
        drive(L, L, 0, 0, L, L, 0, 0);
        rst = 1'b1;
        #1;
        chk("rstrd rvalid during rst", bus.dma_rvalid, 0);
        chk("rstrd dma_rdata during rst", bus.dma_rdata, 0);
        chk("rstrd cpu_rdata during rst", bus.cpu_rdata, 0);
        rst = 1'b0;
        #1; chk("rstrd rvalid after rst", bus.dma_rvalid, 0);
        chk("rstrd dma_rdata after rst", bus.dma_rdata, 0);
        @(posedge clk); #1;
        chk("rstrd rvalid next", bus.dma_rvalid, 0);
        // Counter restarted from zero: DMA forced through on its 5th contested cycle.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(H, H, 32'h60 + k, 32'h0, H, H, 32'h70, 32'h77);
            #1;
            chk($sformatf("starve%0d gnt", k), bus.dma_gnt, (k == 4) ? 1 : 0);
            chk($sformatf("starve%0d stall", k), bus.cpu_stall, (k == 4) ? 1 : 0);
            chk($sformatf("starve%0d addr", k), bus.mem_addr, (k == 4) ? 32'h70 : 32'h60 + k);
        end
        @(posedge clk); #1;
        drive(L, L, 0, 0, L, L, 0, 0);

        // MAX_WAIT = 0: DMA wins every contested cycle.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive0(H, H, 32'h20 + k, H, H, 32'h80 + k);
            #1;
            chk($sformatf("mw0 w%0d gnt", k), bus0.dma_gnt, 1);
            chk($sformatf("mw0 w%0d stall", k), bus0.cpu_stall, 1);
            chk($sformatf("mw0 w%0d addr", k), bus0.mem_addr, 32'h80 + k);
        end
        @(posedge clk); #1;
        drive0(H, L, 32'h10, H, L, 32'h90);
        #1;
        chk("mw0 rd gnt", bus0.dma_gnt, 1);
        chk("mw0 rd stall", bus0.cpu_stall, 1);
        chk("mw0 rd we", bus0.mem_we, 0);
        @(posedge clk); #1;
        drive0(H, L, 32'h10, L, L, 0);
        #1;
        chk("mw0 rvalid", bus0.dma_rvalid, 1);
        chk("mw0 rdata", bus0.dma_rdata, 32'h5A5A0090);
        chk("mw0 ret stall", bus0.cpu_stall, 1);
        @(posedge clk); #1;
        chk("mw0 cpu issue", bus0.mem_addr, 32'h10);
        chk("mw0 cpu stall", bus0.cpu_stall, 1);
        drive0(L, L, 0, L, L, 0);

        // Random traffic against the reference model, starting from a fresh reset and RAM image.
        rst = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        wait_cnt = 0; ret_owner = 0; ret_addr = 8'h0; last_cpu = 32'h0; last_dma = 32'h0;
        hold_cpu = 1'b0; dma_pend = 1'b0;
        cr = 0; cw = 0; ca = 0; cd = 0; dr = 0; dw = 0; da = 0; dd = 0;

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (!hold_cpu) begin
                cr = ($urandom_range(0, 2) != 0);
                cw = $urandom_range(0, 1) == 1;
                ca = $urandom_range(0, 255);
                cd = $urandom;
            end
            if (!dma_pend) begin
                dr = ($urandom_range(0, 2) == 0);
                dw = $urandom_range(0, 1) == 1;
                da = $urandom_range(0, 255);
                dd = $urandom;
            end
            drive(cr, cw, ca, cd, dr, dw, da, dd);
            #1;

            e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_st = 0; e_gn = 0; e_rv = 0;
            e_crd = last_cpu; e_drd = last_dma;
            issue = 0; next_owner = 0;
            if (ret_owner == 1) begin
                e_crd = ref_mem[ret_addr]; last_cpu = e_crd;
            end else if (ret_owner == 2) begin
                e_rv = 1; e_drd = ref_mem[ret_addr]; last_dma = e_drd; e_st = cr;
            end else if (dr && wait_cnt >= MAXW) issue = 2;
            else if (cr) issue = 1;
            else if (dr) issue = 2;

            if (issue == 1) begin
                e_en = 1; e_we = cw; e_addr = ca; e_wd = cd;
                if (!cw) begin e_st = 1; next_owner = 1; ret_addr = ca[7:0]; end
            end else if (issue == 2) begin
                e_en = 1; e_we = dw; e_addr = da; e_wd = dd; e_gn = 1; e_st = cr;
                if (!dw) begin next_owner = 2; ret_addr = da[7:0]; end
            end

            chk($sformatf("rnd%0d mem_en", c), bus.mem_en, e_en);
            chk($sformatf("rnd%0d mem_we", c), bus.mem_we, e_we);
            chk($sformatf("rnd%0d mem_addr", c), bus.mem_addr, e_addr);
            chk($sformatf("rnd%0d mem_wdata", c), bus.mem_wdata, e_wd);
            chk($sformatf("rnd%0d cpu_stall", c), bus.cpu_stall, e_st);
            chk($sformatf("rnd%0d dma_gnt", c), bus.dma_gnt, e_gn);
            chk($sformatf("rnd%0d dma_rvalid", c), bus.dma_rvalid, e_rv);
            chk($sformatf("rnd%0d cpu_rdata", c), bus.cpu_rdata, e_crd);
            chk($sformatf("rnd%0d dma_rdata", c), bus.dma_rdata, e_drd);

            if (e_en && e_we) ref_mem[e_addr[7:0]] = e_wd;
            wait_cnt  = (dr && !e_gn) ? ((wait_cnt + 1 > MAXW) ? MAXW : wait_cnt + 1) : 0;
            ret_owner = next_owner;
            hold_cpu  = e_st;
            dma_pend  = dr && !e_gn;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
